// File: rtl/calendar_alarm_clock_core.sv
// Seconds-resolution calendar clock (2000..2099) with N independent alarms,
// ring/snooze sequencing and 12/24h display conversion. All outputs are binary.
module calendar_alarm_clock_core #(
  parameter int N_ALARMS   = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  localparam int SEL_W     = $clog2(N_ALARMS) + 1
) (
  input  logic                pulse_i,
  input  logic                reset_i,
  input  logic                timeset_i,
  input  logic                alarmset_i,
  input  logic [SEL_W-1:0]    alarm_sel_i,
  input  logic                min_adv_i,
  input  logic                hrs_adv_i,
  input  logic                day_adv_i,
  input  logic                date_adv_i,
  input  logic                month_adv_i,
  input  logic                year_adv_i,
  input  logic [N_ALARMS-1:0] alarmon_i,
  input  logic                snooze_i,
  input  logic                mode12_i,
  output logic [5:0]          secs_o,
  output logic [5:0]          mins_o,
  output logic [4:0]          hrs_o,
  output logic                pm_o,
  output logic [2:0]          day_o,
  output logic [4:0]          date_o,
  output logic [3:0]          month_o,
  output logic [6:0]          year_o,
  output logic [5:0]          alm_mins_o,
  output logic [4:0]          alm_hrs_o,
  output logic                alm_pm_o,
  output logic                buzz_o
);

  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int CNT_MAX      = (SNOOZE_TICKS > RING_SEC) ? SNOOZE_TICKS : RING_SEC;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  function automatic logic [4:0] month_len(input logic [3:0] month, input logic [6:0] year);
    logic [4:0] len;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  // Returns {pm, displayed hour}; pm always reflects the 24h value.
  function automatic logic [5:0] to_display(input logic [4:0] hr24, input logic mode12);
    logic [4:0] hr;
    if (!mode12) begin
      hr = hr24;
    end else if (hr24 == 5'd0) begin
      hr = 5'd12;
    end else if (hr24 > 5'd12) begin
      hr = hr24 - 5'd12;
    end else begin
      hr = hr24;
    end
    return {(hr24 >= 5'd12), hr};
  endfunction

  logic [5:0]       secs_q, secs_d, mins_q, mins_d;
  logic [4:0]       hrs_q, hrs_d, date_q, date_d;
  logic [2:0]       day_q, day_d;
  logic [3:0]       month_q, month_d;
  logic [6:0]       year_q, year_d;
  logic [4:0]       len_cur_s, len_new_s, date_tmp_s;
  logic [5:0]       alm_min_q [N_ALARMS];
  logic [5:0]       alm_min_d [N_ALARMS];
  logic [4:0]       alm_hr_q  [N_ALARMS];
  logic [4:0]       alm_hr_d  [N_ALARMS];
  logic             alm_edit_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] act_q, act_d, hit_idx_s;
  logic [N_ALARMS-1:0] match_s;
  logic             alarmon_act_s, abort_s, sel_valid_s;
  logic [5:0]       alm_min_sel_s;
  logic [4:0]       alm_hr_sel_s;

  // Time/date next state: edit mode forces seconds to 0, run mode carries.
  always_comb begin
    secs_d     = secs_q;
    mins_d     = mins_q;
    hrs_d      = hrs_q;
    day_d      = day_q;
    date_d     = date_q;
    month_d    = month_q;
    year_d     = year_q;
    len_cur_s  = month_len(month_q, year_q);
    len_new_s  = len_cur_s;
    date_tmp_s = date_q;
    if (timeset_i) begin
      secs_d     = 6'd0;
      mins_d     = min_adv_i   ? ((mins_q  >= 6'd59) ? 6'd0 : mins_q  + 6'd1) : mins_q;
      hrs_d      = hrs_adv_i   ? ((hrs_q   >= 5'd23) ? 5'd0 : hrs_q   + 5'd1) : hrs_q;
      day_d      = day_adv_i   ? ((day_q   >= 3'd6)  ? 3'd0 : day_q   + 3'd1) : day_q;
      month_d    = month_adv_i ? ((month_q >= 4'd12) ? 4'd1 : month_q + 4'd1) : month_q;
      year_d     = year_adv_i  ? ((year_q  >= 7'd99) ? 7'd0 : year_q  + 7'd1) : year_q;
      date_tmp_s = date_adv_i  ? ((date_q >= len_cur_s) ? 5'd1 : date_q + 5'd1) : date_q;
      len_new_s  = month_len(month_d, year_d);
      date_d     = (date_tmp_s > len_new_s) ? len_new_s : date_tmp_s;
    end else if (secs_q < 6'd59) begin
      secs_d = secs_q + 6'd1;
    end else begin
      secs_d = 6'd0;
      if (mins_q < 6'd59) begin
        mins_d = mins_q + 6'd1;
      end else begin
        mins_d = 6'd0;
        if (hrs_q < 5'd23) begin
          hrs_d = hrs_q + 5'd1;
        end else begin
          hrs_d = 5'd0;
          day_d = (day_q >= 3'd6) ? 3'd0 : day_q + 3'd1;
          if (date_q < len_cur_s) begin
            date_d = date_q + 5'd1;
          end else begin
            date_d = 5'd1;
            if (month_q < 4'd12) begin
              month_d = month_q + 4'd1;
            end else begin
              month_d = 4'd1;
              year_d  = (year_q >= 7'd99) ? 7'd0 : year_q + 7'd1;
            end
          end
        end
      end
    end
  end

  // Alarm edit: wrap-increment of the selected alarm, suppressed while setting time.
  always_comb begin
    alm_edit_s = alarmset_i && !timeset_i;
    for (int i = 0; i < N_ALARMS; i++) begin
      alm_min_d[i] = (alm_edit_s && min_adv_i && (alarm_sel_i == SEL_W'(i)))
                     ? ((alm_min_q[i] >= 6'd59) ? 6'd0 : alm_min_q[i] + 6'd1) : alm_min_q[i];
      alm_hr_d[i]  = (alm_edit_s && hrs_adv_i && (alarm_sel_i == SEL_W'(i)))
                     ? ((alm_hr_q[i] >= 5'd23) ? 5'd0 : alm_hr_q[i] + 5'd1) : alm_hr_q[i];
    end
  end

  // Alarm match (lowest index wins), active-alarm enable and display selection.
  always_comb begin
    match_s       = {N_ALARMS{1'b0}};
    hit_idx_s     = {SEL_W{1'b0}};
    alarmon_act_s = 1'b0;
    sel_valid_s   = 1'b0;
    alm_min_sel_s = 6'd0;
    alm_hr_sel_s  = 5'd0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      match_s[i]    = alarmon_i[i] && (alm_min_q[i] == mins_q) && (alm_hr_q[i] == hrs_q);
      hit_idx_s     = match_s[i] ? SEL_W'(i) : hit_idx_s;
      alarmon_act_s = alarmon_act_s | (alarmon_i[i] & (act_q == SEL_W'(i)));
      sel_valid_s   = sel_valid_s | (alarm_sel_i == SEL_W'(i));
      alm_min_sel_s = alm_min_sel_s | ((alarm_sel_i == SEL_W'(i)) ? alm_min_q[i] : 6'd0);
      alm_hr_sel_s  = alm_hr_sel_s  | ((alarm_sel_i == SEL_W'(i)) ? alm_hr_q[i]  : 5'd0);
    end
  end

  // Alarm FSM next state: abort beats snooze beats counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    abort_s = !alarmon_act_s || timeset_i;
    case (state_q)
      ST_IDLE: begin
        if (!timeset_i && (secs_q == 6'd0) && (|match_s)) begin
          state_d = ST_RING;
          cnt_d   = CNT_W'(RING_SEC);
          act_d   = hit_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RING: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_W'(0);
        end else if (snooze_i) begin
          state_d = ST_SNOOZE;
          cnt_d   = CNT_W'(SNOOZE_TICKS);
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_W'(0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SNOOZE: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_W'(0);
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RING;
          cnt_d   = CNT_W'(RING_SEC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge pulse_i) begin
    if (reset_i) begin
      secs_q  <= 6'd0;
      mins_q  <= 6'd0;
      hrs_q   <= 5'd0;
      day_q   <= 3'd0;
      date_q  <= 5'd1;
      month_q <= 4'd1;
      year_q  <= 7'd0;
      for (int i = 0; i < N_ALARMS; i++) begin
        alm_min_q[i] <= 6'd0;
        alm_hr_q[i]  <= 5'd0;
      end
      state_q <= ST_IDLE;
      cnt_q   <= CNT_W'(0);
      act_q   <= {SEL_W{1'b0}};
    end else begin
      secs_q  <= secs_d;
      mins_q  <= mins_d;
      hrs_q   <= hrs_d;
      day_q   <= day_d;
      date_q  <= date_d;
      month_q <= month_d;
      year_q  <= year_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        alm_min_q[i] <= alm_min_d[i];
        alm_hr_q[i]  <= alm_hr_d[i];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
    end
  end

  assign secs_o           = secs_q;
  assign mins_o           = mins_q;
  assign {pm_o, hrs_o}    = to_display(hrs_q, mode12_i);
  assign day_o            = day_q;
  assign date_o           = date_q;
  assign month_o          = month_q;
  assign year_o           = year_q;
  assign alm_mins_o       = alm_min_sel_s;
  assign {alm_pm_o, alm_hrs_o} = sel_valid_s ? to_display(alm_hr_sel_s, mode12_i) : 6'd0;
  assign buzz_o           = (state_q == ST_RING);

endmodule

// File: tb/tb_calendar_alarm_clock_core.sv
// Bench for calendar_alarm_clock_core: directed calendar/alarm scenarios plus a random
// phase, all checked against a seconds-of-day / minutes-of-day reference model.
module tb_calendar_alarm_clock_core;

  localparam int N_ALARMS   = 2;
  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 60;

  logic       pulse = 1'b0;
  logic       reset, timeset, alarmset, snooze, mode12;
  logic [1:0] alarm_sel, alarmon;
  logic       min_adv, hrs_adv, day_adv, date_adv, month_adv, year_adv;
  logic [5:0] secs, mins, alm_mins;
  logic [4:0] hrs, date, alm_hrs;
  logic [2:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       pm, alm_pm, buzz;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_sod, m_day, m_date, m_month, m_year;
  int m_am [N_ALARMS];
  int m_ring, m_snz, m_act;

  calendar_alarm_clock_core #(.N_ALARMS(N_ALARMS), .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
    .pulse_i(pulse), .reset_i(reset), .timeset_i(timeset), .alarmset_i(alarmset),
    .alarm_sel_i(alarm_sel), .min_adv_i(min_adv), .hrs_adv_i(hrs_adv), .day_adv_i(day_adv),
    .date_adv_i(date_adv), .month_adv_i(month_adv), .year_adv_i(year_adv),
    .alarmon_i(alarmon), .snooze_i(snooze), .mode12_i(mode12),
    .secs_o(secs), .mins_o(mins), .hrs_o(hrs), .pm_o(pm), .day_o(day), .date_o(date),
    .month_o(month), .year_o(year), .alm_mins_o(alm_mins), .alm_hrs_o(alm_hrs),
    .alm_pm_o(alm_pm), .buzz_o(buzz)
  );

  always #5 pulse = ~pulse;

  function automatic int mlen(input int mo, input int yr);
    if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic int disp_hr(input int h, input logic m12);
    if (!m12) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sod = 0; m_day = 0; m_date = 1; m_month = 1; m_year = 0;
    for (int i = 0; i < N_ALARMS; i++) m_am[i] = 0;
    m_ring = 0; m_snz = 0; m_act = 0;
  endtask

  task automatic model_step();
    bit found = 1'b0;
    int idx = 0;
    int hr, mn, nd, s;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_ring == 0 && m_snz == 0) begin
      if (!timeset && (m_sod % 60 == 0)) begin
        for (int i = N_ALARMS - 1; i >= 0; i--)
          if (alarmon[i] && m_am[i] == m_sod / 60) begin found = 1'b1; idx = i; end
        if (found) begin m_ring = RING_SEC; m_act = idx; end
      end
    end else if (!alarmon[m_act] || timeset) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring > 0) begin
      if (snooze) begin m_ring = 0; m_snz = SNOOZE_MIN * 60; end
      else m_ring--;
    end else begin
      m_snz--;
      if (m_snz == 0) m_ring = RING_SEC;
    end
    if (timeset) begin
      hr = m_sod / 3600; mn = (m_sod / 60) % 60;
      if (min_adv) mn = (mn + 1) % 60;
      if (hrs_adv) hr = (hr + 1) % 24;
      m_sod = hr * 3600 + mn * 60;
      if (day_adv) m_day = (m_day + 1) % 7;
      nd = m_date;
      if (date_adv) nd = (m_date == mlen(m_month, m_year)) ? 1 : m_date + 1;
      if (month_adv) m_month = m_month % 12 + 1;
      if (year_adv) m_year = (m_year + 1) % 100;
      m_date = (nd > mlen(m_month, m_year)) ? mlen(m_month, m_year) : nd;
    end else begin
      s = int'(alarm_sel);
      if (alarmset && s < N_ALARMS) begin
        hr = m_am[s] / 60; mn = m_am[s] % 60;
        if (min_adv) mn = (mn + 1) % 60;
        if (hrs_adv) hr = (hr + 1) % 24;
        m_am[s] = hr * 60 + mn;
      end
      m_sod++;
      if (m_sod == 86400) begin
        m_sod = 0;
        m_day = (m_day + 1) % 7;
        if (m_date == mlen(m_month, m_year)) begin
          m_date = 1;
          if (m_month == 12) begin m_month = 1; m_year = (m_year + 1) % 100; end
          else m_month++;
        end else m_date++;
      end
    end
  endtask

  task automatic check_all();
    int h, s, ah;
    h = m_sod / 3600;
    s = int'(alarm_sel);
    chk("secs", secs, m_sod % 60);
    chk("mins", mins, (m_sod / 60) % 60);
    chk("hrs", hrs, disp_hr(h, mode12));
    chk("pm", pm, h >= 12);
    chk("day", day, m_day);
    chk("date", date, m_date);
    chk("month", month, m_month);
    chk("year", year, m_year);
    if (s < N_ALARMS) begin
      ah = m_am[s] / 60;
      chk("alm_mins", alm_mins, m_am[s] % 60);
      chk("alm_hrs", alm_hrs, disp_hr(ah, mode12));
      chk("alm_pm", alm_pm, ah >= 12);
    end else begin
      chk("alm_mins_inv", alm_mins, 0);
      chk("alm_hrs_inv", alm_hrs, 0);
      chk("alm_pm_inv", alm_pm, 0);
    end
    chk("buzz", buzz, m_ring > 0);
  endtask

  task automatic step();
    model_step();
    @(posedge pulse);
    #1;
    check_all();
  endtask

  task automatic clear_advs();
    min_adv = 1'b0; hrs_adv = 1'b0; day_adv = 1'b0;
    date_adv = 1'b0; month_adv = 1'b0; year_adv = 1'b0;
  endtask

  task automatic set_time(input int yr, input int mo, input int dt, input int hr, input int mn);
    clear_advs();
    timeset = 1'b1;
    step();
    for (int k = 0; k < 130; k++) begin
      min_adv   = ((m_sod / 60) % 60 != mn);
      hrs_adv   = (m_sod / 3600 != hr);
      month_adv = (m_month != mo);
      year_adv  = (m_year != yr);
      if (!(min_adv || hrs_adv || month_adv || year_adv)) break;
      step();
    end
    clear_advs();
    for (int k = 0; k < 40; k++) begin
      date_adv = (m_date != dt);
      if (!date_adv) break;
      step();
    end
    clear_advs();
    timeset = 1'b0;
  endtask

  task automatic set_alarm(input int idx, input int hr, input int mn);
    alarmset = 1'b1;
    alarm_sel = 2'(idx);
    for (int k = 0; k < 90; k++) begin
      min_adv = (m_am[idx] % 60 != mn);
      hrs_adv = (m_am[idx] / 60 != hr);
      if (!(min_adv || hrs_adv)) break;
      step();
    end
    clear_advs();
    alarmset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1; timeset = 1'b0; alarmset = 1'b0; snooze = 1'b0; mode12 = 1'b0;
    alarm_sel = 2'd0; alarmon = 2'b00;
    clear_advs();
    model_reset();
    step();
    reset = 1'b0;
    chk("rst_date", date, 1);
    chk("rst_month", month, 1);
    chk("rst_buzz", buzz, 0);

    // free run across minute and hour carries
    for (int k = 0; k < 3700; k++) begin
      mode12 = 1'($urandom_range(0, 1));
      step();
    end
    mode12 = 1'b0;

    // leap-year and year rollovers
    set_time(0, 2, 28, 23, 59);
    run(60);
    chk("leap_date", date, 29);
    chk("leap_month", month, 2);
    chk("leap_hrs", hrs, 0);
    set_time(1, 2, 28, 23, 59);
    run(60);
    chk("nonleap_date", date, 1);
    chk("nonleap_month", month, 3);
    set_time(99, 12, 31, 23, 59);
    run(60);
    chk("y99_year", year, 0);
    chk("y99_month", month, 1);
    chk("y99_date", date, 1);

    // edit-mode clamp and minute wrap without carry
    set_time(0, 1, 31, 10, 59);
    timeset = 1'b1; month_adv = 1'b1;
    step();
    chk("clamp_month", month, 2);
    chk("clamp_date", date, 29);
    month_adv = 1'b0; min_adv = 1'b1;
    step();
    chk("minwrap_mins", mins, 0);
    chk("minwrap_hrs", hrs, 10);
    clear_advs();
    timeset = 1'b0;

    // single alarm ring length
    set_alarm(0, 7, 30);
    set_time(0, 1, 1, 7, 29);
    alarmon = 2'b01;
    run(59);
    step();
    chk("ring_at_match", buzz, 0);
    step();
    chk("ring_start", buzz, 1);
    run(59);
    chk("ring_last", buzz, 1);
    step();
    chk("ring_end", buzz, 0);

    // snooze then re-ring, then disable mid-ring
    set_time(0, 1, 1, 7, 29);
    run(60);
    step();
    run(3);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snooze_start", buzz, 0);
    run(299);
    chk("snooze_last", buzz, 0);
    step();
    chk("snooze_rering", buzz, 1);
    run(5);
    alarmon = 2'b00;
    step();
    chk("disable_stop", buzz, 0);

    // two alarms at the same time: lowest index owns the ring
    set_alarm(0, 6, 0);
    set_alarm(1, 6, 0);
    set_time(0, 1, 1, 5, 59);
    alarmon = 2'b11;
    run(60);
    step();
    chk("dual_ring", buzz, 1);
    alarmon = 2'b01;
    step();
    chk("dual_drop1", buzz, 1);
    run(3);
    alarmon = 2'b10;
    step();
    chk("dual_drop0", buzz, 0);
    alarmon = 2'b00;

    // 12h display corners
    mode12 = 1'b1;
    set_time(0, 1, 1, 0, 0);
    chk("m12_h0", hrs, 12);
    chk("m12_pm0", pm, 0);
    set_time(0, 1, 1, 13, 0);
    chk("m12_h13", hrs, 1);
    chk("m12_pm13", pm, 1);
    alarm_sel = 2'd3;
    step();
    chk("sel_inv_hrs", alm_hrs, 0);

    // randomized mixed stimulus, alarms seeded near the current time
    mode12 = 1'b0;
    set_alarm(0, (m_sod / 3600), ((m_sod / 60) % 60 + 2) % 60);
    for (int k = 0; k < 2500; k++) begin
      reset     = ($urandom_range(0, 299) == 0);
      timeset   = ($urandom_range(0, 19) == 0);
      alarmset  = ($urandom_range(0, 5) == 0);
      alarm_sel = 2'($urandom_range(0, 3));
      min_adv   = ($urandom_range(0, 3) == 0);
      hrs_adv   = ($urandom_range(0, 3) == 0);
      day_adv   = ($urandom_range(0, 3) == 0);
      date_adv  = ($urandom_range(0, 3) == 0);
      month_adv = ($urandom_range(0, 3) == 0);
      year_adv  = ($urandom_range(0, 3) == 0);
      alarmon   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      snooze    = ($urandom_range(0, 30) == 0);
      mode12    = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
